wb_cellram_sched: RTL and testbench
===================================

WB_CELLRAM_SCHED -- requirements
Module: wb_cellram_sched

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: max consecutive M0 grants while M1 waits.
REQ-002 Parameter TIMEOUT, default 64: cycles without slave ack before a bus error.
REQ-003 wb_clk_i  in  1  single clock; all state updates on the rising edge.
REQ-004 wb_rst_n_i  in  1  asynchronous, active-low reset.
REQ-005 wb_m0_adr_i  in  32  video-cache master address (read-only master).
REQ-006 wb_m0_sel_i  in  4  M0 byte selects.
REQ-007 wb_m0_cyc_i  in  1  M0 bus cycle.
REQ-008 wb_m0_stb_i  in  1  M0 strobe.
REQ-009 wb_m0_dat_o  out  32  read data to M0.
REQ-010 wb_m0_ack_o  out  1  ack to M0.
REQ-011 wb_m0_err_o  out  1  timeout error to M0.
REQ-012 wb_m1_adr_i  in  32  CPU/BIU master address.
REQ-013 wb_m1_dat_i  in  32  M1 write data.
REQ-014 wb_m1_sel_i  in  4  M1 byte selects.
REQ-015 wb_m1_cyc_i  in  1  M1 bus cycle.
REQ-016 wb_m1_stb_i  in  1  M1 strobe.
REQ-017 wb_m1_we_i  in  1  M1 write enable.
REQ-018 wb_m1_dat_o  out  32  read data to M1.
REQ-019 wb_m1_ack_o  out  1  ack to M1.
REQ-020 wb_m1_err_o  out  1  timeout error to M1.
REQ-021 wb_s_adr_o / wb_s_dat_o / wb_s_sel_o  out  32/32/4  to cellram controller.
REQ-022 wb_s_cyc_o / wb_s_stb_o / wb_s_we_o  out  1 each  to cellram controller.
REQ-023 wb_s_dat_i  in  32  read data from cellram controller.
REQ-024 wb_s_ack_i  in  1  ack from cellram controller.
REQ-025 cellram_mst_sel  out  2  owner: 00 none, 01 M0, 10 M1.

Function
REQ-026 FSM states: IDLE, GNT_M0, GNT_M1, ERR.
- cellram_mst_sel = 00/01/10/00 respectively.
REQ-027 Request definition: request = cyc_i & stb_i.
- Decision is made in IDLE only; the grant state is entered on the next edge (1-cycle arbitration latency).
REQ-028 Arbitration priority:
- M0 alone -> GNT_M0; M1 alone -> GNT_M1.
- Both requesting -> GNT_M0, unless starve_cnt == STARVE_LIMIT, then GNT_M1.
REQ-029 starve_cnt behaviour:
- +1 on each IDLE->GNT_M0 decision while M1 is requesting, saturating at STARVE_LIMIT.
- Cleared to 0 on every IDLE->GNT_M1 decision.
REQ-030 Slave outputs in a grant state: combinational mux of the owner's signals.
- GNT_M0 forces wb_s_we_o = 0 and wb_s_dat_o = 0.
- IDLE and ERR drive all wb_s_* outputs to 0.
REQ-031 Master-side data and ack routing:
- Owner: dat_o = wb_s_dat_i, ack_o = wb_s_ack_i.
- Non-owner: dat_o = 0, ack_o = 0, err_o = 0.
REQ-032 Tenure: ownership is held while the owner's cyc_i = 1, allowing multiple strobes and acks.
- Owner cyc_i = 0 -> IDLE on the next edge.
- Exactly one IDLE cycle always separates tenures.
REQ-033 Watchdog wd_cnt:
- Cleared on grant entry and on every wb_s_ack_i.
- Increments each grant-state cycle with owner stb_i = 1 and no ack.
- When wd_cnt == TIMEOUT-1 without ack -> ERR.
REQ-034 ERR lasts exactly 1 cycle, then IDLE.
- err_o = 1 to the recorded owner during ERR, 0 otherwise.
REQ-035 Ack and timeout in the same cycle: ack wins (no ERR).
REQ-036 wb_s_ack_i while in IDLE or ERR is ignored and not forwarded.

Reset
REQ-037 Reset value while wb_rst_n_i = 0:
- FSM = IDLE; starve_cnt = 0; wd_cnt = 0.
- All outputs = 0, including cellram_mst_sel = 00.
- Takes effect immediately, including mid-tenure; the aborted transfer is not acked.
REQ-038 Reset release: the first arbitration decision happens on the first rising edge after wb_rst_n_i = 1.

Verification
REQ-039 Single M1 write: adr 0x100, dat 0xDEADBEEF, we = 1; slave acks 4 cycles after grant -> wb_s_* match M1, wb_m1_ack_o for 1 cycle, mst_sel 10, then 00.
REQ-040 Both request continuously, each tenure 1 ack:
- Required grant order: M0 x4, then M1, then M0 x4, then M1.
- starve_cnt resets to 0 after each M1 grant.
REQ-041 M0 burst: cyc held for 8 acks while M1 requests -> M1 is not granted until M0 drops cyc, plus the 1 IDLE cycle.
REQ-042 Slave never acks M1 -> wb_m1_err_o = 1 exactly at cycle 64 after grant; slave cyc/stb drop; FSM returns to IDLE; M0 is then serviceable.
REQ-043 wb_rst_n_i pulsed low mid-tenure in GNT_M0 -> all outputs 0 asynchronously; after release, a pending M1 request is granted on the first edge.
REQ-044 Ack arriving on cycle 64 (coincident with timeout) -> ack forwarded, no err_o.

Source files
------------

// File: rtl/wb_cellram_sched.sv
// Two-master Wishbone scheduler in front of a CellularRAM controller.
// M0 (video cache) is preferred; M1 gets a slot after STARVE_LIMIT back-to-back M0 wins.
module wb_cellram_sched #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic [31:0] wb_m0_adr_i,
  input  logic [3:0]  wb_m0_sel_i,
  input  logic        wb_m0_cyc_i,
  input  logic        wb_m0_stb_i,
  output logic [31:0] wb_m0_dat_o,
  output logic        wb_m0_ack_o,
  output logic        wb_m0_err_o,
  input  logic [31:0] wb_m1_adr_i,
  input  logic [31:0] wb_m1_dat_i,
  input  logic [3:0]  wb_m1_sel_i,
  input  logic        wb_m1_cyc_i,
  input  logic        wb_m1_stb_i,
  input  logic        wb_m1_we_i,
  output logic [31:0] wb_m1_dat_o,
  output logic        wb_m1_ack_o,
  output logic        wb_m1_err_o,
  output logic [31:0] wb_s_adr_o,
  output logic [31:0] wb_s_dat_o,
  output logic [3:0]  wb_s_sel_o,
  output logic        wb_s_cyc_o,
  output logic        wb_s_stb_o,
  output logic        wb_s_we_o,
  input  logic [31:0] wb_s_dat_i,
  input  logic        wb_s_ack_i,
  output logic [1:0]  cellram_mst_sel
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GNT_M0 = 2'd1,
    S_GNT_M1 = 2'd2,
    S_ERR    = 2'd3
  } state_t;

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);
  localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT - 1);

  state_t          r_state, w_state_next;
  logic [SC_W-1:0] r_starve_cnt, w_starve_next;
  logic [WD_W-1:0] r_wd_cnt, w_wd_next;
  logic            r_err_m1, w_err_m1_next;

  logic w_m0_req, w_m1_req, w_own_cyc, w_own_stb, w_timeout, w_m1_wins;

  assign w_m0_req  = wb_m0_cyc_i & wb_m0_stb_i;
  assign w_m1_req  = wb_m1_cyc_i & wb_m1_stb_i;
  assign w_m1_wins = w_m1_req & (~w_m0_req | (r_starve_cnt == STARVE_MAX));

  assign w_own_cyc = (r_state == S_GNT_M0) ? wb_m0_cyc_i :
                     (r_state == S_GNT_M1) ? wb_m1_cyc_i : 1'b0;
  assign w_own_stb = (r_state == S_GNT_M0) ? wb_m0_stb_i :
                     (r_state == S_GNT_M1) ? wb_m1_stb_i : 1'b0;
  // A coincident ack always beats the watchdog.
  assign w_timeout = w_own_stb & ~wb_s_ack_i & (r_wd_cnt == WD_LAST);

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state      <= S_IDLE;
      r_starve_cnt <= '0;
      r_wd_cnt     <= '0;
      r_err_m1     <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_starve_cnt <= w_starve_next;
      r_wd_cnt     <= w_wd_next;
      r_err_m1     <= w_err_m1_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_starve_next = r_starve_cnt;
    w_wd_next     = r_wd_cnt;
    w_err_m1_next = r_err_m1;
    case (r_state)
      S_IDLE: begin
        w_wd_next = '0;
        if (w_m1_wins) begin
          w_state_next  = S_GNT_M1;
          w_starve_next = '0;
        end else if (w_m0_req) begin
          w_state_next = S_GNT_M0;
          // Reaching here with M1 waiting implies the count is below its limit.
          if (w_m1_req) w_starve_next = r_starve_cnt + 1'b1;
        end
      end
      S_GNT_M0, S_GNT_M1: begin
        if (!w_own_cyc) begin
          w_state_next = S_IDLE;
        end else if (w_timeout) begin
          w_state_next  = S_ERR;
          w_err_m1_next = (r_state == S_GNT_M1);
        end
        if (wb_s_ack_i)     w_wd_next = '0;
        else if (w_own_stb) w_wd_next = r_wd_cnt + 1'b1;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    wb_s_adr_o      = '0;
    wb_s_dat_o      = '0;
    wb_s_sel_o      = '0;
    wb_s_cyc_o      = 1'b0;
    wb_s_stb_o      = 1'b0;
    wb_s_we_o       = 1'b0;
    wb_m0_dat_o     = '0;
    wb_m0_ack_o     = 1'b0;
    wb_m0_err_o     = 1'b0;
    wb_m1_dat_o     = '0;
    wb_m1_ack_o     = 1'b0;
    wb_m1_err_o     = 1'b0;
    cellram_mst_sel = 2'b00;
    case (r_state)
      S_GNT_M0: begin
        wb_s_adr_o      = wb_m0_adr_i;
        wb_s_sel_o      = wb_m0_sel_i;
        wb_s_cyc_o      = wb_m0_cyc_i;
        wb_s_stb_o      = wb_m0_stb_i;
        wb_m0_dat_o     = wb_s_dat_i;
        wb_m0_ack_o     = wb_s_ack_i;
        cellram_mst_sel = 2'b01;
      end
      S_GNT_M1: begin
        wb_s_adr_o      = wb_m1_adr_i;
        wb_s_dat_o      = wb_m1_dat_i;
        wb_s_sel_o      = wb_m1_sel_i;
        wb_s_cyc_o      = wb_m1_cyc_i;
        wb_s_stb_o      = wb_m1_stb_i;
        wb_s_we_o       = wb_m1_we_i;
        wb_m1_dat_o     = wb_s_dat_i;
        wb_m1_ack_o     = wb_s_ack_i;
        cellram_mst_sel = 2'b10;
      end
      S_ERR: begin
        wb_m0_err_o = ~r_err_m1;
        wb_m1_err_o = r_err_m1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_cellram_sched.sv
// Bench for wb_cellram_sched: master/slave agents feed per-master scoreboards and a grant-order queue.
// Inputs change 1-2 time units after the rising edge; everything is observed on the falling edge.
module tb_wb_cellram_sched;

  localparam logic [31:0] RD_KEY = 32'hA5A5_0000;
  typedef struct packed { logic err; logic [31:0] dat; } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] m0_adr = 32'h0000_1000;
  logic [3:0]  m0_sel = 4'hF;
  logic        m0_cyc = 1'b0, m0_stb = 1'b0;
  logic [31:0] m0_dat_o;
  logic        m0_ack, m0_err;
  logic [31:0] m1_adr = '0, m1_dat = '0;
  logic [3:0]  m1_sel = 4'hC;
  logic        m1_cyc = 1'b0, m1_stb = 1'b0, m1_we = 1'b0;
  logic [31:0] m1_dat_o;
  logic        m1_ack, m1_err;
  logic [31:0] s_adr, s_dat_o;
  logic [3:0]  s_sel;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_dat_i = '0;
  logic        s_ack = 1'b0;
  logic [1:0]  mst_sel;

  int tests = 0, fails = 0;
  int m0_total = 0, m0_done = 0, m0_burst = 1, m0_in_ten = 0;
  int m1_total = 0, m1_done = 0;
  logic [31:0] m1_adr_cfg = '0, m1_dat_cfg = '0;
  logic        m1_we_cfg = 1'b0, m1_exp_err = 1'b0;
  logic        slv_en = 1'b1;
  int          slv_lat = 1, slv_cnt = 0;
  logic smp_m0_ack = 1'b0, smp_m0_err = 1'b0, smp_m1_ack = 1'b0, smp_m1_err = 1'b0;
  logic [1:0] prev_sel = 2'b00;

  exp_t       q0[$];
  exp_t       q1[$];
  logic [1:0] exp_gnt[$];

  wb_cellram_sched #(.STARVE_LIMIT(4), .TIMEOUT(64)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .wb_m0_adr_i(m0_adr), .wb_m0_sel_i(m0_sel), .wb_m0_cyc_i(m0_cyc), .wb_m0_stb_i(m0_stb),
    .wb_m0_dat_o(m0_dat_o), .wb_m0_ack_o(m0_ack), .wb_m0_err_o(m0_err),
    .wb_m1_adr_i(m1_adr), .wb_m1_dat_i(m1_dat), .wb_m1_sel_i(m1_sel), .wb_m1_cyc_i(m1_cyc),
    .wb_m1_stb_i(m1_stb), .wb_m1_we_i(m1_we),
    .wb_m1_dat_o(m1_dat_o), .wb_m1_ack_o(m1_ack), .wb_m1_err_o(m1_err),
    .wb_s_adr_o(s_adr), .wb_s_dat_o(s_dat_o), .wb_s_sel_o(s_sel),
    .wb_s_cyc_o(s_cyc), .wb_s_stb_o(s_stb), .wb_s_we_o(s_we),
    .wb_s_dat_i(s_dat_i), .wb_s_ack_i(s_ack),
    .cellram_mst_sel(mst_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [159:0] all_outputs();
    return {m0_dat_o, m0_ack, m0_err, m1_dat_o, m1_ack, m1_err,
            s_adr, s_dat_o, s_sel, s_cyc, s_stb, s_we, mst_sel};
  endfunction

  task automatic wait_sel(input logic [1:0] v, input int budget, input string name);
    int n = 0;
    while (mst_sel !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, mst_sel, v);
  endtask

  task automatic wait_quiet(input int budget, input string name);
    int n = 0;
    while (!(m0_done == m0_total && m1_done == m1_total && !m0_cyc && !m1_cyc &&
             mst_sel == 2'b00) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {m0_total - m0_done, m1_total - m1_done, mst_sel, m0_cyc, m1_cyc}, '0);
    repeat (2) @(negedge clk);
  endtask

  // Sample master-side responses for the agents.
  initial begin
    forever begin
      @(negedge clk);
      smp_m0_ack = m0_ack;
      smp_m0_err = m0_err;
      smp_m1_ack = m1_ack;
      smp_m1_err = m1_err;
    end
  end

  // Master agents, then the slave model, each cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        if (m0_cyc) begin
          m0_cyc = 1'b0;
          m0_stb = 1'b0;
          q0.delete();
          m0_done = m0_total;
        end
      end else if (m0_cyc) begin
        if (smp_m0_ack || smp_m0_err) begin
          m0_done++;
          m0_in_ten++;
          if (smp_m0_err || m0_in_ten == m0_burst || m0_done == m0_total) begin
            m0_cyc = 1'b0;
            m0_stb = 1'b0;
          end else begin
            m0_adr = m0_adr + 32'd4;
            e.err = 1'b0;
            e.dat = m0_adr ^ RD_KEY;
            q0.push_back(e);
          end
        end
      end else if (m0_done < m0_total) begin
        m0_adr = m0_adr + 32'd4;
        m0_cyc = 1'b1;
        m0_stb = 1'b1;
        m0_in_ten = 0;
        e.err = 1'b0;
        e.dat = m0_adr ^ RD_KEY;
        q0.push_back(e);
      end

      if (m1_cyc) begin
        if (smp_m1_ack || smp_m1_err) begin
          m1_done++;
          m1_cyc = 1'b0;
          m1_stb = 1'b0;
          m1_we  = 1'b0;
        end
      end else if (m1_done < m1_total && rst_n) begin
        m1_adr = m1_adr_cfg;
        m1_dat = m1_dat_cfg;
        m1_we  = m1_we_cfg;
        m1_cyc = 1'b1;
        m1_stb = 1'b1;
        e.err = m1_exp_err;
        e.dat = m1_exp_err ? 32'h0 : (m1_adr_cfg ^ RD_KEY);
        q1.push_back(e);
      end

      #1;
      if (s_ack) begin
        s_ack = 1'b0;
        slv_cnt = 0;
      end else if (s_cyc && s_stb && slv_en) begin
        slv_cnt++;
        if (slv_cnt >= slv_lat) begin
          s_ack = 1'b1;
          s_dat_i = s_adr ^ RD_KEY;
          slv_cnt = 0;
        end
      end else begin
        slv_cnt = 0;
      end
    end
  end

  // Monitor: grant order, slave-bus mux at grant, and master responses.
  initial begin
    exp_t e;
    logic [1:0] g;
    forever begin
      @(negedge clk);
      if (mst_sel != prev_sel && mst_sel != 2'b00) begin
        if (exp_gnt.size() == 0) begin
          check("grant_unexpected", mst_sel, 2'b00);
        end else begin
          g = exp_gnt.pop_front();
          check("grant_order", mst_sel, g);
        end
        check("grant_after_idle", prev_sel, 2'b00);
        if (mst_sel == 2'b01)
          check("s_bus_m0", {s_adr, s_dat_o, s_sel, s_we, s_cyc, s_stb},
                {m0_adr, 32'h0, m0_sel, 1'b0, m0_cyc, m0_stb});
        else
          check("s_bus_m1", {s_adr, s_dat_o, s_sel, s_we, s_cyc, s_stb},
                {m1_adr, m1_dat, m1_sel, m1_we, m1_cyc, m1_stb});
        $display("[TB] grant sel=%b", mst_sel);
      end
      prev_sel = mst_sel;
      if (m0_ack || m0_err) begin
        if (q0.size() == 0) begin
          check("m0_resp_unexpected", {m0_ack, m0_err}, 2'b00);
        end else begin
          e = q0.pop_front();
          check("m0_resp", {m0_ack, m0_err, m0_dat_o}, {~e.err, e.err, e.dat});
        end
        $display("[TB] M0 ack=%b err=%b dat=%08h", m0_ack, m0_err, m0_dat_o);
      end
      if (m1_ack || m1_err) begin
        if (q1.size() == 0) begin
          check("m1_resp_unexpected", {m1_ack, m1_err}, 2'b00);
        end else begin
          e = q1.pop_front();
          check("m1_resp", {m1_ack, m1_err, m1_dat_o}, {~e.err, e.err, e.dat});
        end
        $display("[TB] M1 ack=%b err=%b dat=%08h", m1_ack, m1_err, m1_dat_o);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outputs(), '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single M1 write.
    m1_adr_cfg = 32'h0000_0100;
    m1_dat_cfg = 32'hDEAD_BEEF;
    m1_we_cfg  = 1'b1;
    slv_lat    = 4;
    exp_gnt.push_back(2'b10);
    m1_total++;
    wait_sel(2'b10, 20, "m1_write_grant");
    check("m1_write_s_bus", {s_adr, s_dat_o, s_sel, s_we, s_cyc, s_stb},
          {32'h0000_0100, 32'hDEAD_BEEF, 4'hC, 1'b1, 1'b1, 1'b1});
    n = 0;
    while (!m1_ack && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("m1_write_ack_cycle", {n, m1_ack}, {32'd3, 1'b1});
    @(negedge clk);
    check("m1_write_ack_single", {m1_ack, mst_sel}, {1'b0, 2'b10});
    @(negedge clk);
    check("m1_write_release", mst_sel, 2'b00);
    wait_quiet(50, "m1_write_done");

    // Both masters contend; starvation bound lets M1 in every fifth grant.
    m1_adr_cfg = 32'h0000_0200;
    m1_dat_cfg = 32'h1111_2222;
    m1_we_cfg  = 1'b0;
    slv_lat    = 1;
    m0_burst   = 1;
    exp_gnt.push_back(2'b01); exp_gnt.push_back(2'b01);
    exp_gnt.push_back(2'b01); exp_gnt.push_back(2'b01);
    exp_gnt.push_back(2'b10);
    exp_gnt.push_back(2'b01); exp_gnt.push_back(2'b01);
    exp_gnt.push_back(2'b01); exp_gnt.push_back(2'b01);
    exp_gnt.push_back(2'b10);
    m0_total += 8;
    m1_total += 2;
    wait_quiet(500, "contend_done");

    // M0 burst of 8 holds ownership while M1 waits.
    m0_burst = 8;
    m1_adr_cfg = 32'h0000_0240;
    exp_gnt.push_back(2'b01);
    exp_gnt.push_back(2'b10);
    m0_total += 8;
    m1_total += 1;
    wait_quiet(300, "burst_done");
    m0_burst = 1;

    // Slave never acks M1: watchdog error.
    slv_en     = 1'b0;
    m1_exp_err = 1'b1;
    m1_adr_cfg = 32'h0000_0300;
    exp_gnt.push_back(2'b10);
    m1_total++;
    wait_sel(2'b10, 20, "timeout_grant");
    n = 0;
    while (!m1_err && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("timeout_err_cycle", n, 64);
    check("timeout_err_bus", {s_cyc, s_stb, mst_sel, m0_err}, '0);
    @(negedge clk);
    check("timeout_err_single", {m1_err, mst_sel}, {1'b0, 2'b00});
    m1_exp_err = 1'b0;
    slv_en     = 1'b1;
    exp_gnt.push_back(2'b01);
    m0_total++;
    wait_quiet(100, "timeout_then_m0");

    // Ack lands on the timeout cycle: ack wins.
    slv_lat    = 64;
    m1_adr_cfg = 32'h0000_0400;
    exp_gnt.push_back(2'b10);
    m1_total++;
    wait_sel(2'b10, 20, "ack_vs_to_grant");
    n = 0;
    while (!(m1_ack || m1_err) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ack_vs_to_cycle", {n, m1_ack, m1_err}, {32'd63, 1'b1, 1'b0});
    wait_quiet(100, "ack_vs_to_done");

    // Reset pulse in the middle of an M0 tenure with M1 pending.
    slv_lat = 40;
    exp_gnt.push_back(2'b01);
    m0_total++;
    wait_sel(2'b01, 20, "rst_m0_grant");
    m1_adr_cfg = 32'h0000_0500;
    exp_gnt.push_back(2'b10);
    m1_total++;
    repeat (8) @(negedge clk);
    check("rst_pre_owner", mst_sel, 2'b01);
    #2 rst_n = 1'b0;
    #1 check("rst_async_outputs", all_outputs(), '0);
    slv_lat = 2;
    repeat (3) @(negedge clk);
    check("rst_held_outputs", all_outputs(), '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_grant", mst_sel, 2'b10);
    wait_quiet(100, "rst_done");

    check("sb_q0_empty", q0.size(), 0);
    check("sb_q1_empty", q1.size(), 0);
    check("grant_q_empty", exp_gnt.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
